// File: rtl/bitserial_sub_pkg.sv
// Shared constants, state type and helpers for the bit-serial subtractor.
package bitserial_sub_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        SHIFT = ST_SHIFT,
        DONE  = ST_DONE
    } state_t;

    // Bits needed to count 0 .. value-1.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/bitserial_sub_full_sub_cell.sv
// One-bit full subtractor: the subtract-direction mirror of the team's full adder.
module full_sub_cell (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = x ^ y ^ bin;
    assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/bitserial_sub.sv
// LSB-first bit-serial subtractor (diff = a - b) behind a start/done handshake.
// Define BITSERIAL_SUB_OVF_EN to add the registered signed-overflow output ovf.
module bitserial_sub
    import bitserial_sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
`ifdef BITSERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CNT_W = clog2(WIDTH);

    state_t               state;
    logic [WIDTH-1:0]     a_sh;
    logic [WIDTH-1:0]     b_sh;
    logic [WIDTH-2:0]     res_sh;
    logic [WIDTH-1:0]     res_cat;
    logic [CNT_W-1:0]     cnt;
    logic                 borrow;
    logic                 cell_d;
    logic                 cell_bout;

    full_sub_cell u_cell (
        .x    (a_sh[0]),
        .y    (b_sh[0]),
        .bin  (borrow),
        .d    (cell_d),
        .bout (cell_bout)
    );

    // Result register with the current cell output already shifted in.
    assign res_cat = {cell_d, res_sh};

    always_ff @(posedge clk) begin
        // NOTE: all sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (rst) begin
            // NOTE: a_sh, b_sh and res_sh are deliberately not reset; they are
            // fully reloaded or overwritten before any of their bits is used.
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
            borrow     <= 1'b0;
            cnt        <= '0;
`ifdef BITSERIAL_SUB_OVF_EN
            ovf        <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sh   <= a;
                        b_sh   <= b;
                        borrow <= 1'b0;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    res_sh <= res_cat[WIDTH-1:1];
                    borrow <= cell_bout;
                    cnt    <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        diff       <= res_cat;
                        borrow_out <= cell_bout;
`ifdef BITSERIAL_SUB_OVF_EN
                        // Signed overflow: borrow into the MSB cell differs from borrow out.
                        ovf        <= borrow ^ cell_bout;
`endif
                        state      <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bitserial_sub.sv
// Randomised self-checking bench for bitserial_sub at WIDTH=8 plus a WIDTH=4 sweep.
module tb_bitserial_sub;

    logic       clk = 1'b0;
    logic       rst;
    logic       start8, start4;
    logic [7:0] a8, b8, diff8;
    logic [3:0] a4, b4, diff4;
    logic       busy8, done8, bo8;
    logic       busy4, done4, bo4;
`ifdef BITSERIAL_SUB_OVF_EN
    logic       ovf8, ovf4;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    bitserial_sub #(.WIDTH(8)) dut8 (
        .clk        (clk),
        .rst        (rst),
        .start      (start8),
        .a          (a8),
        .b          (b8),
        .busy       (busy8),
        .done       (done8),
        .diff       (diff8),
        .borrow_out (bo8)
`ifdef BITSERIAL_SUB_OVF_EN
        ,
        .ovf        (ovf8)
`endif
    );

    bitserial_sub #(.WIDTH(4)) dut4 (
        .clk        (clk),
        .rst        (rst),
        .start      (start4),
        .a          (a4),
        .b          (b4),
        .busy       (busy4),
        .done       (done4),
        .diff       (diff4),
        .borrow_out (bo4)
`ifdef BITSERIAL_SUB_OVF_EN
        ,
        .ovf        (ovf4)
`endif
    );

    task automatic test_reset();
        rst = 1'b1; start8 = 1'b0; start4 = 1'b0;
        a8 = 8'h00; b8 = 8'h00; a4 = 4'h0; b4 = 4'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests++;
        if ({busy8, done8, diff8, bo8} !== 11'd0) begin
            fails++;
            $display("FAIL reset8: busy=%b done=%b diff=%h borrow=%b, required all 0",
                     busy8, done8, diff8, bo8);
        end
        tests++;
        if ({busy4, done4, diff4, bo4} !== 7'd0) begin
            fails++;
            $display("FAIL reset4: busy=%b done=%b diff=%h borrow=%b, required all 0",
                     busy4, done4, diff4, bo4);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    // One full transaction with cycle-exact latency and output-hold checks.
    task automatic run_op(input logic [7:0] op_a, input logic [7:0] op_b);
        logic [7:0] exp_d, prev_d;
        logic       exp_b, prev_b;
        exp_d = op_a - op_b;
        exp_b = (op_a < op_b);
        prev_d = diff8;
        prev_b = bo8;
        a8 = op_a; b8 = op_b; start8 = 1'b1;
        @(posedge clk);
        #1;
        start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            tests++;
            if (busy8 !== 1'b1 || done8 !== 1'b0 || diff8 !== prev_d || bo8 !== prev_b) begin
                fails++;
                $display("FAIL busy_phase %h-%h cycle %0d: busy=%b done=%b diff=%h borrow=%b, required busy=1 done=0 diff=%h borrow=%b",
                         op_a, op_b, k, busy8, done8, diff8, bo8, prev_d, prev_b);
            end
        end
        @(negedge clk);
        tests++;
        if (done8 !== 1'b1 || busy8 !== 1'b0) begin
            fails++;
            $display("FAIL done_pulse %h-%h: done=%b busy=%b, required done=1 busy=0",
                     op_a, op_b, done8, busy8);
        end
        tests++;
        if (diff8 !== exp_d || bo8 !== exp_b) begin
            fails++;
            $display("FAIL result %h-%h: diff=%h borrow=%b, required diff=%h borrow=%b",
                     op_a, op_b, diff8, bo8, exp_d, exp_b);
        end
`ifdef BITSERIAL_SUB_OVF_EN
        tests++;
        if (ovf8 !== ((op_a[7] != op_b[7]) && (exp_d[7] != op_a[7]))) begin
            fails++;
            $display("FAIL ovf %h-%h: ovf=%b, required %b", op_a, op_b, ovf8,
                     (op_a[7] != op_b[7]) && (exp_d[7] != op_a[7]));
        end
`endif
        @(negedge clk);
        tests++;
        if (done8 !== 1'b0 || busy8 !== 1'b0) begin
            fails++;
            $display("FAIL idle_after %h-%h: done=%b busy=%b, required 0 0",
                     op_a, op_b, done8, busy8);
        end
    endtask

    task automatic test_directed();
        run_op(8'h05, 8'h03);
        run_op(8'h03, 8'h05);
        run_op(8'h00, 8'hFF);
        run_op(8'hA5, 8'hA5);
    endtask

    task automatic test_random();
        for (int i = 0; i < 20; i++) run_op(8'($urandom), 8'($urandom));
    endtask

    task automatic test_back_to_back();
        logic [7:0] qa [50];
        logic [7:0] qb [50];
        logic [7:0] exp_d;
        for (int n = 0; n < 50; n++) begin
            qa[n] = 8'($urandom);
            qb[n] = 8'($urandom);
            a8 = qa[n]; b8 = qb[n]; start8 = 1'b1;
            @(posedge clk);
            @(negedge clk);
            // Accepts land on every tenth edge; n counts edges from the first accept.
            tests++;
            if (done8 !== (n % 10 == 8) || busy8 !== (n % 10 <= 7)) begin
                fails++;
                $display("FAIL b2b_timing edge %0d: done=%b busy=%b, required done=%b busy=%b",
                         n, done8, busy8, (n % 10 == 8), (n % 10 <= 7));
            end
            if (n % 10 == 8) begin
                exp_d = qa[n-8] - qb[n-8];
                tests++;
                if (diff8 !== exp_d || bo8 !== (qa[n-8] < qb[n-8])) begin
                    fails++;
                    $display("FAIL b2b_result edge %0d: diff=%h borrow=%b, required diff=%h borrow=%b",
                             n, diff8, bo8, exp_d, (qa[n-8] < qb[n-8]));
                end
            end
        end
        start8 = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        run_op(8'h03, 8'h05);
        a8 = 8'h05; b8 = 8'h03; start8 = 1'b1;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tests++;
        if ({busy8, done8, diff8, bo8} !== 11'd0) begin
            fails++;
            $display("FAIL reset_mid: busy=%b done=%b diff=%h borrow=%b, required all 0",
                     busy8, done8, diff8, bo8);
        end
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            tests++;
            if (done8 !== 1'b0 || busy8 !== 1'b0) begin
                fails++;
                $display("FAIL reset_mid_quiet cycle %0d: done=%b busy=%b, required 0 0",
                         k, done8, busy8);
            end
        end
        // rst and start together: the start must be dropped.
        rst = 1'b1; start8 = 1'b1; a8 = 8'h77; b8 = 8'h11;
        @(negedge clk);
        rst = 1'b0; start8 = 1'b0;
        @(negedge clk);
        tests++;
        if (busy8 !== 1'b0 || done8 !== 1'b0) begin
            fails++;
            $display("FAIL rst_start_same: busy=%b done=%b, required 0 0", busy8, done8);
        end
        run_op(8'h10, 8'h01);
    endtask

`ifdef BITSERIAL_SUB_OVF_EN
    task automatic test_ovf();
        run_op(8'h80, 8'h01);
        run_op(8'h7F, 8'hFF);
        run_op(8'h05, 8'h03);
    endtask
`endif

    task automatic test_sweep4();
        bit seen;
        for (int ai = 0; ai < 16; ai++) begin
            for (int bi = 0; bi < 16; bi++) begin
                @(negedge clk);
                a4 = 4'(ai); b4 = 4'(bi); start4 = 1'b1;
                @(posedge clk);
                #1;
                start4 = 1'b0;
                seen = 1'b0;
                for (int k = 0; k < 12 && !seen; k++) begin
                    @(negedge clk);
                    if (done4 === 1'b1) seen = 1'b1;
                end
                tests++;
                if (!seen) begin
                    fails++;
                    $display("FAIL sweep4_timeout %0d-%0d: no done within 12 cycles", ai, bi);
                end else if (diff4 !== 4'((ai - bi) & 15) || bo4 !== (ai < bi)) begin
                    fails++;
                    $display("FAIL sweep4 %0d-%0d: diff=%h borrow=%b, required diff=%h borrow=%b",
                             ai, bi, diff4, bo4, 4'((ai - bi) & 15), (ai < bi));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_mid();
`ifdef BITSERIAL_SUB_OVF_EN
        test_ovf();
`endif
        test_sweep4();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/bitserial_sub.md
Name: bitserial_sub

Overview:
- Bit-serial subtractor computing diff = a - b.
- Operands are processed LSB-first, one bit per clock, through a single full-subtractor cell with a registered borrow.
- It is the inverse-operation companion to the team's combinational full adder: the subtract direction, sequentialised to trade area for latency.
- Sits as a small arithmetic slave behind a start/done handshake.

Parameters:
- WIDTH, 8, operand and result width in bits (legal range 2..32).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- start  input  1  request pulse; sampled only in IDLE.
- a  input  WIDTH  minuend; captured on the accepted start edge.
- b  input  WIDTH  subtrahend; captured on the accepted start edge.
- busy  output  1  high while a subtraction is in progress (SHIFT state).
- done  output  1  one-cycle pulse; diff and borrow_out are valid from this cycle.
- diff  output  WIDTH  a - b modulo 2^WIDTH.
- borrow_out  output  1  final borrow; 1 when unsigned a < b.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high.
- Reset values:
  - state = IDLE.
  - busy = 0, done = 0, diff = 0, borrow_out = 0.
  - Borrow flop and bit counter = 0.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - On the edge where start = 1: load a_sh <= a, b_sh <= b, borrow <= 0, cnt <= 0, go to SHIFT.
  - Otherwise stay in IDLE.
- SHIFT, each edge:
  - Cell inputs: x = a_sh[0], y = b_sh[0], bin = borrow.
  - Cell outputs: d = x ^ y ^ bin; bout = (~x & y) | (~(x ^ y) & bin).
  - Right-shift a_sh and b_sh.
  - Shift d into the MSB of the result shift register.
  - borrow <= bout; cnt <= cnt + 1.
  - On the edge where cnt == WIDTH-1: go to DONE, load diff from the completed result, borrow_out <= bout.
- DONE: lasts exactly one cycle with done = 1, then returns to IDLE unconditionally.
- Latency:
  - Start accepted at edge E.
  - busy = 1 for cycles E+1 .. E+WIDTH.
  - done = 1 in cycle E+WIDTH+1.
  - Next start is accepted at the earliest edge E+WIDTH+2 (first IDLE cycle).
- start while busy or in DONE: ignored; operands are not re-sampled; no queueing.
- Operand stability: a and b are needed only on the accepted edge and may change afterwards.
- Output hold: diff and borrow_out keep their value until the next DONE or rst. They do not change while busy.
- Reset mid-operation: rst in any state forces IDLE on that edge and clears all outputs; the partial result is discarded; done never pulses.
- rst and start in the same cycle: rst wins; start is dropped.
- Arithmetic:
  - Result is modulo 2^WIDTH.
  - borrow_out equals the carry-complement of a + ~b + 1, i.e. unsigned a < b.
  - a == b gives diff = 0, borrow_out = 0.
- busy and done are never high together.

Optional Feature:
- Macro: BITSERIAL_SUB_OVF_EN
- Defined:
  - Adds output port ovf (1 bit, reset 0), loaded at DONE and held like diff.
  - ovf = 1 when signed two's-complement subtraction overflows: a[MSB] != b[MSB] and diff[MSB] != a[MSB].
  - Implemented by XOR of the borrow into and out of the MSB cell.
- Undefined: port ovf is absent; no extra logic.

Decomposition:
- Package bitserial_sub_pkg:
  - State encoding localparams ST_IDLE = 2'd0, ST_SHIFT = 2'd1, ST_DONE = 2'd2.
  - Default WIDTH constant.
  - Counter width function clog2(WIDTH).
- Sub-module full_sub_cell: purely combinational, ports x, y, bin, d, bout. It is the one-bit mirror of the existing full adder and is instantiated once in the datapath.

Test Plan:
- WIDTH=8, a=0x05, b=0x03, start pulse -> busy for 8 cycles; done in cycle 9 after accept; diff=0x02, borrow_out=0.
- a=0x03, b=0x05 -> diff=0xFE, borrow_out=1. Also a=0x00, b=0xFF -> diff=0x01, borrow_out=1. Also a=b=0xA5 -> diff=0x00, borrow_out=0.
- Hold start high continuously with operands changing each cycle -> accepts occur exactly every 10 cycles; each result matches the operands on its accept edge; no back-to-back done.
- Start with 0x05-0x03, assert rst at busy cycle 4 -> next cycle all outputs 0, state IDLE; no done pulse. A new start 0x10-0x01 then yields diff=0x0F.
- With BITSERIAL_SUB_OVF_EN: 0x80-0x01 -> diff=0x7F, ovf=1. Also 0x7F-0xFF -> diff=0x80, ovf=1. Also 0x05-0x03 -> ovf=0. Without the macro the build has no ovf port.
- Exhaustive sweep, WIDTH=4: all 256 (a,b) pairs -> diff == (a-b) & 0xF and borrow_out == (a<b), checked at each done.
